// File: rtl/cbrt_seq_param_if.sv
// ---------------------------------------------------------------------------
// cbrt_seq_param_if
//   Request/result bundle for the sequential cube-root unit.
//   Optional macro: CBRT_REM_EN adds the rem_bo signal (x - y^3).
//
//   Signals (named from the unit's point of view):
//     start_i  1  request, sampled by the unit only while idle
//     x_bi     W  radicand, captured when start_i is accepted
//     busy_o   1  unit is working (high in every non-idle state)
//     done_o   1  one-cycle pulse, y_bo/rem_bo valid and updated
//     y_bo     R  floor(cbrt(x)), held until the next done_o
//     rem_bo   W  x - y_bo^3 (only with CBRT_REM_EN)
//
//   Modports: master = requester, slave = cube-root unit.
// ---------------------------------------------------------------------------
interface cbrt_seq_param_if #(
    parameter int W = 8
);
    localparam int R = (W + 2) / 3;

    logic         start_i;
    logic [W-1:0] x_bi;
    logic         busy_o;
    logic         done_o;
    logic [R-1:0] y_bo;
`ifdef CBRT_REM_EN
    logic [W-1:0] rem_bo;

    modport master (output start_i, x_bi, input busy_o, done_o, y_bo, rem_bo);
    modport slave  (input start_i, x_bi, output busy_o, done_o, y_bo, rem_bo);
`else
    modport master (output start_i, x_bi, input busy_o, done_o, y_bo);
    modport slave  (input start_i, x_bi, output busy_o, done_o, y_bo);
`endif
endinterface

// File: rtl/cbrt_seq_param.sv
// ---------------------------------------------------------------------------
// cbrt_seq_param
//   Sequential unsigned integer cube root, y = floor(cbrt(x)), for a W-bit
//   radicand. Digit-by-digit restoring recurrence, one result bit per
//   iteration; the y*(y+1) product is formed by an internal shift-add
//   multiplier.
//   Optional macro: CBRT_REM_EN registers the remainder x - y^3 on rem_bo.
//
//   Parameters: W (>= 3) radicand width; R = ceil(W/3) result width.
//   Ports:
//     clk_i  1  clock, rising edge
//     rst_i  1  asynchronous, active-high reset
//     bus    cbrt_seq_param_if.slave (start_i, x_bi, busy_o, done_o,
//            y_bo, rem_bo)
//
//   Latency: busy_o is high R*(R+3)+1 cycles after the accepting edge;
//   done_o marks the last of them.
// ---------------------------------------------------------------------------
module cbrt_seq_param #(
    parameter int W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    cbrt_seq_param_if.slave       bus
);
    localparam int R  = (W + 2) / 3;       // result bits
    localparam int PW = 2 * R + 1;         // y*(y+1) product width
    localparam int BW = 5 * R + 2;         // full-precision trial width
    localparam int SW = $clog2(3 * R);     // shift amount 0..3(R-1)
    localparam int IW = $clog2(R + 1);     // iteration count R..1
    localparam int MW = $clog2(R + 2);     // multiplier step 0..R

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        MUL,
        CMP,
        DONE
    } state_t;

    state_t state, state_next;

    logic [W-1:0]  arg;       // running remainder
    logic [R-1:0]  y;         // partial root
    logic [SW-1:0] s;         // weight of the current digit (multiple of 3)
    logic [IW-1:0] i;         // iterations left, including the current one
    logic [PW-1:0] mcand;     // multiplicand, shifted left each step
    logic [R:0]    mplier;    // multiplier, shifted right each step
    logic [PW-1:0] p;         // product accumulator
    logic [MW-1:0] mcnt;      // multiplier step counter

    // Trial subtrahend (3p+1) << s, kept wide enough that it never wraps
    // even for the top digit of an all-ones radicand.
    logic [BW-1:0] p_ext;
    logic [BW-1:0] trial;
    logic          fits;
    logic [W-1:0]  arg_sub;
    logic [R-1:0]  y_new;

    assign p_ext   = BW'(p);
    assign trial   = ((p_ext << 1) + p_ext + BW'(1)) << s;
    assign fits    = BW'(arg) >= trial;
    // Only consumed when fits, where trial <= arg < 2^W.
    assign arg_sub = arg - trial[W-1:0];
    // After doubling y ends in 0, so accepting the digit just sets bit 0.
    assign y_new   = fits ? (y | R'(1)) : y;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // branch can leave one unassigned and infer a latch.
        state_next  = state;
        bus.busy_o  = 1'b1;
        bus.done_o  = 1'b0;
        unique case (state)
            IDLE: begin
                bus.busy_o = 1'b0;
                if (bus.start_i) state_next = PREP;
            end
            PREP: state_next = MUL;
            MUL:  if (mcnt == MW'(R)) state_next = CMP;
            CMP:  state_next = (i == IW'(1)) ? DONE : PREP;
            DONE: begin
                bus.done_o = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: every register is cleared, result included, so an abort
            // never leaves a partial root visible on y_bo.
            arg      <= '0;
            y        <= '0;
            s        <= '0;
            i        <= '0;
            mcand    <= '0;
            mplier   <= '0;
            p        <= '0;
            mcnt     <= '0;
            bus.y_bo <= '0;
`ifdef CBRT_REM_EN
            bus.rem_bo <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        arg <= bus.x_bi;
                        y   <= '0;
                        s   <= SW'(3 * (R - 1));
                        i   <= IW'(R);
                    end
                end
                PREP: begin
                    // a = 2y and b = 2y+1 for the doubled partial root.
                    y      <= y << 1;
                    mcand  <= PW'({y, 1'b0});
                    mplier <= {y, 1'b1};
                    p      <= '0;
                    mcnt   <= '0;
                end
                MUL: begin
                    if (mplier[0]) p <= p + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    mcnt   <= mcnt + MW'(1);
                end
                CMP: begin
                    if (fits) arg <= arg_sub;
                    y <= y_new;
                    i <= i - IW'(1);
                    if (i == IW'(1)) begin
                        // Result lands with the transition to DONE so it is
                        // already valid while done_o is high.
                        bus.y_bo <= y_new;
`ifdef CBRT_REM_EN
                        bus.rem_bo <= fits ? arg_sub : arg;
`endif
                    end else begin
                        s <= s - SW'(3);
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cbrt_seq_param.sv
// ---------------------------------------------------------------------------
// tb_cbrt_seq_param
//   Directed bench for cbrt_seq_param at W=8 and W=16. Remainder checks are
//   compiled in only when CBRT_REM_EN is defined.
// ---------------------------------------------------------------------------
module tb_cbrt_seq_param;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cbrt_seq_param_if #(.W(8))  bus8 ();
    cbrt_seq_param_if #(.W(16)) bus16 ();

    cbrt_seq_param #(.W(8))  dut8  (.clk_i(clk), .rst_i(rst), .bus(bus8));
    cbrt_seq_param #(.W(16)) dut16 (.clk_i(clk), .rst_i(rst), .bus(bus16));

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic busy_of(input int which);
        return (which == 8) ? bus8.busy_o : bus16.busy_o;
    endfunction

    function automatic logic done_of(input int which);
        return (which == 8) ? bus8.done_o : bus16.done_o;
    endfunction

    // Called at a falling edge; starts immediately, so back-to-back calls
    // issue start_i in the first idle cycle after DONE.
    // poke_at > 0 pulses a second start (x=8) on that busy cycle.
    task automatic run(input string tag, input int which, input int x,
                       input int exp_y, input int exp_rem, input int exp_busy,
                       input int poke_at);
        int cycles, dones, y_seen, rem_seen;
        cycles = 0; dones = 0; y_seen = -1; rem_seen = -1;
        if (which == 8) begin
            bus8.start_i = 1'b1;  bus8.x_bi = x[7:0];
        end else begin
            bus16.start_i = 1'b1; bus16.x_bi = x[15:0];
        end
        @(negedge clk);
        bus8.start_i = 1'b0; bus16.start_i = 1'b0;
        while (busy_of(which) && cycles < 400) begin
            cycles++;
            if (done_of(which)) begin
                dones++;
                y_seen = (which == 8) ? int'(bus8.y_bo) : int'(bus16.y_bo);
`ifdef CBRT_REM_EN
                rem_seen = (which == 8) ? int'(bus8.rem_bo) : int'(bus16.rem_bo);
`endif
            end
            if (poke_at > 0 && cycles == poke_at) begin
                bus8.start_i = 1'b1; bus8.x_bi = 8'd8;
            end else begin
                bus8.start_i = 1'b0;
            end
            @(negedge clk);
        end
        bus8.start_i = 1'b0;
        check({tag, "_timeout"}, 32'(cycles >= 400), 32'd0);
        check({tag, "_busy_cycles"}, cycles, exp_busy);
        check({tag, "_done_pulses"}, dones, 1);
        check({tag, "_y"}, y_seen, exp_y);
`ifdef CBRT_REM_EN
        check({tag, "_rem"}, rem_seen, exp_rem);
`else
        if (exp_rem < 0) $display("unexpected negative remainder argument");
`endif
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus8.start_i = 1'b0;  bus8.x_bi = '0;
        bus16.start_i = 1'b0; bus16.x_bi = '0;
        @(negedge clk); @(negedge clk);
        check("rst_busy8",  bus8.busy_o,  0);
        check("rst_done8",  bus8.done_o,  0);
        check("rst_y8",     bus8.y_bo,    0);
        check("rst_busy16", bus16.busy_o, 0);
        check("rst_y16",    bus16.y_bo,   0);
`ifdef CBRT_REM_EN
        check("rst_rem8",   bus8.rem_bo,  0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors, back-to-back with no idle gap between them.
        run("x27",   8, 27,    3,  0,    19, 0);
        run("x255",  8, 255,   6,  39,   19, 0);
        run("x7",    8, 7,     1,  6,    19, 0);
        run("x0",    8, 0,     0,  0,    19, 0);
        run("x65535", 16, 65535, 40, 1535, 55, 0);

        // Second request mid-operation must be ignored, not queued.
        run("x125_poke", 8, 125, 5, 0, 19, 5);
        @(negedge clk);
        check("no_queue_busy", bus8.busy_o, 0);
        check("hold_y", bus8.y_bo, 5);

        // Asynchronous reset in the middle of the multiply phase.
        bus8.start_i = 1'b1; bus8.x_bi = 8'd255;
        @(negedge clk);                 // PREP
        bus8.start_i = 1'b0;
        @(negedge clk);                 // MUL
        check("mul_busy", bus8.busy_o, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", bus8.busy_o, 0);
        check("abort_done", bus8.done_o, 0);
        check("abort_y",    bus8.y_bo,   0);
`ifdef CBRT_REM_EN
        check("abort_rem",  bus8.rem_bo, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run("x64_after_abort", 8, 64, 4, 0, 19, 0);

        // Exhaustive W=8 sweep against a brute-force reference.
        for (int x = 0; x < 256; x++) begin
            int ry;
            ry = 0;
            while ((ry + 1) * (ry + 1) * (ry + 1) <= x) ry++;
            run("sweep", 8, x, ry, x - ry * ry * ry, 19, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
